bitwise_reduce_seq: RTL and testbench
=====================================

// Module: bitwise_reduce_seq
// PURPOSE
//  Sequential, parametrised successor to the single-bit 2-input AND gate.
//  - Reduces a stream of WIDTH-bit operands, presented one per beat over a valid/ready handshake, into one result per frame.
//  - Reduction is bitwise AND, OR, XOR or NAND, selected per frame.
//  - Sits between an operand source and a result consumer; both sides may stall.
// PARAMETERS
//  WIDTH    8   operand/result width in bits (>=1)
//  MAX_OPS  16  max operands per frame (>=1); frame force-closed at this count
// PORTS
//  clk        in   1              rising-edge clock
//  rst        in   1              synchronous, active-high reset
//  mode       in   2              00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat of frame
//  in_data    in   WIDTH          operand
//  in_valid   in   1              operand valid
//  in_last    in   1              operand is last of frame
//  in_ready   out  1              block accepts operand this cycle
//  out_data   out  WIDTH          reduced result
//  out_count  out  $clog2(MAX_OPS+1)  operands in this frame
//  out_err    out  1              frame truncated at MAX_OPS without in_last
//  out_valid  out  1              result valid
//  out_ready  in   1              consumer accepts result
// BEHAVIOUR
//  Reset (rst=1 at posedge):
//   - state=IDLE; acc=0; count=0; mode_q=00.
//   - out_data=0, out_count=0, out_err=0, out_valid=0.
//   - in_ready=0 while rst high.
//  Beat accepted when in_valid && in_ready; result taken when out_valid && out_ready.
//  in_ready = !rst && state!=HOLD (combinational from state).
//  FSM states IDLE, ACC, HOLD:
//   IDLE, on accept:
//    - acc<=in_data; count<=1; mode_q<=mode.
//    - If in_last or MAX_OPS==1 -> HOLD, else -> ACC.
//   ACC, on accept:
//    - acc<=op(mode_q, acc, in_data); count<=count+1.
//    - If in_last -> HOLD.
//    - Else if count+1==MAX_OPS -> HOLD with err set.
//    - Without accept: hold state.
//   HOLD:
//    - out_valid=1; in_ready=0.
//    - On out_ready -> IDLE, out_valid drops next cycle.
//  op: AND and NAND accumulate with &; OR with |; XOR with ^.
//   - NAND inverts only the final result: out_data=~acc.
//  Result registers load on the HOLD-entry edge:
//   - out_data, out_count and out_err are valid the cycle after the closing beat is accepted (latency 1).
//   - They hold stable throughout HOLD regardless of other inputs.
//   - They retain their last value after the handoff; out_valid alone qualifies them.
//  mode changes mid-frame are ignored; mode_q holds until the next frame's first beat.
//  Truncation:
//   - The beat after a forced close is the first beat of a new frame, even if it carries in_last.
//   - No beats are dropped.
//  No overlap: a new frame cannot start until the result is taken.
//   - Minimum frame period = beats + 1 cycle, plus any out_ready stall.
//  out_count width: $clog2(MAX_OPS+1); count never exceeds MAX_OPS.
//  in_last/in_data are ignored when in_valid=0.
//  Reset mid-frame or mid-HOLD:
//   - Partial frame and pending result are discarded, with no output.
//   - The next accepted beat starts a fresh frame.
// TESTING (WIDTH=8, MAX_OPS=16 unless noted)
//  1. AND frame F0,3C,FF(last) -> out_data=30, count=3, err=0, out_valid 1 cycle after last.
//  2. XOR single beat A5(last) -> out_data=A5, count=1; NAND FF,0F(last) -> out_data=F0.
//  3. Backpressure: out_ready=0 for 5 cycles in HOLD
//     -> out_* stable, in_ready=0, in_valid beats not consumed; release -> IDLE next cycle.
//  4. MAX_OPS=4, OR 01,02,04,08,10(last)
//     -> result 0F count=4 err=1; then 10 count=1 err=0.
//  5. Mode toggled AND->OR after beat 1 of AND frame 0F,F0(last) -> out_data=00 (AND kept).
//  6. rst for 1 cycle after 2 beats of a frame
//     -> out_valid=0, in_ready=0 during rst; then AND 0F(last) -> out_data=0F, count=1.

Source files
------------

// File: rtl/bitwise_reduce_seq.sv
// bitwise_reduce_seq: folds a stream of WIDTH-bit operands into one
// AND/OR/XOR/NAND result per frame. Valid/ready on both sides; one frame
// in flight at a time. A frame closes on in_last or when MAX_OPS operands
// have been taken (out_err flags the forced close).
module bitwise_reduce_seq #(
  parameter  int WIDTH   = 8,
  parameter  int MAX_OPS = 16,
  localparam int CW      = $clog2(MAX_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    out_count,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [1:0] M_OR   = 2'b01;
  localparam logic [1:0] M_XOR  = 2'b10;
  localparam logic [1:0] M_NAND = 2'b11;

  typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    count;
  logic [1:0]       mode_q;

  logic             accept;
  logic [CW-1:0]    count_inc;
  logic [WIDTH-1:0] acc_op;
  logic [WIDTH-1:0] first_res;
  logic [WIDTH-1:0] acc_res;

  // NAND folds like AND; the inversion is applied once to the final value.
  function automatic logic [WIDTH-1:0] fold(input logic [1:0] m,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    case (m)
      M_OR:    fold = a | b;
      M_XOR:   fold = a ^ b;
      default: fold = a & b;
    endcase
  endfunction

  assign in_ready  = !rst && (state != HOLD);
  assign accept    = in_valid && in_ready;
  assign count_inc = count + CW'(1);
  assign acc_op    = fold(mode_q, acc, in_data);
  // single-beat frames use the live mode, since mode_q is loaded on the same edge
  assign first_res = (mode   == M_NAND) ? ~in_data : in_data;
  assign acc_res   = (mode_q == M_NAND) ? ~acc_op  : acc_op;

  // Frame FSM: accumulate beats, load result registers on HOLD entry,
  // release the result on out_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      mode_q    <= 2'b00;
      out_data  <= '0;
      out_count <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            acc    <= in_data;
            count  <= CW'(1);
            mode_q <= mode;
            if (in_last || MAX_OPS == 1) begin
              state     <= HOLD;
              out_data  <= first_res;
              out_count <= CW'(1);
              // only reachable without in_last when MAX_OPS==1
              out_err   <= !in_last;
              out_valid <= 1'b1;
            end else begin
              state <= ACC;
            end
          end
        end
        ACC: begin
          if (accept) begin
            acc   <= acc_op;
            count <= count_inc;
            if (in_last || count_inc == CW'(MAX_OPS)) begin
              state     <= HOLD;
              out_data  <= acc_res;
              out_count <= count_inc;
              out_err   <= !in_last;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bitwise_reduce_seq.sv
// Bench for bitwise_reduce_seq: two instances (MAX_OPS 16 and 4) share one
// stimulus stream. A per-instance model keeps the operands of the open frame
// in a list and reduces the list when the frame closes; every cycle the DUT
// outputs are compared with it. Directed frames add literal expectations.
module tb_bitwise_reduce_seq;

  logic       clk;
  logic       rst;
  logic [1:0] mode;
  logic [7:0] in_data;
  logic       in_valid, in_last, out_ready;

  logic       rdy0, ov0, oe0, rdy1, ov1, oe1;
  logic [7:0] od0, od1;
  logic [4:0] oc0;
  logic [2:0] oc1;

  int total = 0;
  int bad   = 0;

  bitwise_reduce_seq #(.WIDTH(8), .MAX_OPS(16)) u16 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy0), .out_data(od0), .out_count(oc0),
    .out_err(oe0), .out_valid(ov0), .out_ready(out_ready));

  bitwise_reduce_seq #(.WIDTH(8), .MAX_OPS(4)) u4 (
    .clk(clk), .rst(rst), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_last(in_last), .in_ready(rdy1), .out_data(od1), .out_count(oc1),
    .out_err(oe1), .out_valid(ov1), .out_ready(out_ready));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state, index 0 -> MAX_OPS 16, index 1 -> MAX_OPS 4
  logic [7:0] ops [2][16];
  int         n   [2];
  logic [1:0] fm  [2];
  bit         hold[2];
  logic [7:0] ed  [2];
  int         ec  [2];
  bit         ee  [2];

  function automatic int maxops(input int i);
    return (i == 0) ? 16 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs about to be sampled.
  task automatic model_step();
    logic [7:0] r;
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        n[i] = 0; hold[i] = 0; ed[i] = 8'h00; ec[i] = 0; ee[i] = 0;
      end else if (hold[i]) begin
        if (out_ready) hold[i] = 0;
      end else if (in_valid) begin
        if (n[i] == 0) fm[i] = mode;
        ops[i][n[i]] = in_data;
        n[i]++;
        if (in_last || n[i] == maxops(i)) begin
          r = ops[i][0];
          for (int k = 1; k < n[i]; k++) begin
            case (fm[i])
              2'b01:   r = r | ops[i][k];
              2'b10:   r = r ^ ops[i][k];
              default: r = r & ops[i][k];
            endcase
          end
          if (fm[i] == 2'b11) r = ~r;
          ed[i] = r; ec[i] = n[i]; ee[i] = !in_last; hold[i] = 1; n[i] = 0;
        end
      end
    end
  endtask

  task automatic compare();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("u%0d out_valid", i), (i == 0) ? ov0 : ov1, hold[i]);
      chk($sformatf("u%0d in_ready", i), (i == 0) ? rdy0 : rdy1, !rst && !hold[i]);
      chk($sformatf("u%0d out_data", i), (i == 0) ? od0 : od1, ed[i]);
      chk($sformatf("u%0d out_count", i), (i == 0) ? 32'(oc0) : 32'(oc1), ec[i]);
      chk($sformatf("u%0d out_err", i), (i == 0) ? oe0 : oe1, ee[i]);
    end
  endtask

  // One clock: apply inputs, step the model, check after the edge.
  task automatic cyc(input bit v, input logic [1:0] m, input logic [7:0] d,
                     input bit l, input bit ordy);
    in_valid = v; mode = m; in_data = d; in_last = l; out_ready = ordy;
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 0; mode = 0; in_data = 0; in_last = 0; out_ready = 0;
    for (int k = 0; k < 16; k++) begin ops[0][k] = 0; ops[1][k] = 0; end
    for (int i = 0; i < 2; i++) begin
      n[i] = 0; fm[i] = 0; hold[i] = 0; ed[i] = 0; ec[i] = 0; ee[i] = 0;
    end

    // reset state
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(0, 2'b00, 8'h00, 0, 1);
    chk("rst out_valid", ov0, 1'b0);
    chk("rst in_ready", rdy0, 1'b0);
    chk("rst out_data", od0, 8'h00);
    chk("rst out_count", oc0, 5'd0);
    rst = 1'b0;
    cyc(0, 2'b00, 8'h00, 0, 1);
    chk("idle in_ready", rdy0, 1'b1);

    // AND F0,3C,FF
    cyc(1, 2'b00, 8'hF0, 0, 1);
    cyc(1, 2'b00, 8'h3C, 0, 1);
    cyc(1, 2'b00, 8'hFF, 1, 1);
    chk("and valid", ov0, 1'b1);
    chk("and data", od0, 8'h30);
    chk("and count", oc0, 5'd3);
    chk("and err", oe0, 1'b0);
    cyc(0, 2'b00, 8'h00, 0, 1);
    chk("and handoff", ov0, 1'b0);

    // XOR single beat, NAND FF,0F
    cyc(1, 2'b10, 8'hA5, 1, 1);
    chk("xor data", od0, 8'hA5);
    chk("xor count", oc0, 5'd1);
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(1, 2'b11, 8'hFF, 0, 1);
    cyc(1, 2'b11, 8'h0F, 1, 1);
    chk("nand data", od0, 8'hF0);
    cyc(0, 2'b00, 8'h00, 0, 1);

    // backpressure in HOLD with beats offered
    cyc(1, 2'b00, 8'h0F, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 2'b01, 8'hAA, 1, 0);
      chk("bp data", od0, 8'h0F);
      chk("bp in_ready", rdy0, 1'b0);
      chk("bp valid", ov0, 1'b1);
    end
    cyc(0, 2'b00, 8'h00, 0, 1);
    chk("bp release valid", ov0, 1'b0);
    chk("bp release ready", rdy0, 1'b1);

    // truncation: OR 01,02,04,08 then 10(last)
    cyc(1, 2'b01, 8'h01, 0, 1);
    cyc(1, 2'b01, 8'h02, 0, 1);
    cyc(1, 2'b01, 8'h04, 0, 1);
    cyc(1, 2'b01, 8'h08, 0, 1);
    chk("trunc data", od1, 8'h0F);
    chk("trunc count", oc1, 3'd4);
    chk("trunc err", oe1, 1'b1);
    cyc(0, 2'b00, 8'h00, 0, 1);
    cyc(1, 2'b01, 8'h10, 1, 1);
    chk("post trunc data", od1, 8'h10);
    chk("post trunc count", oc1, 3'd1);
    chk("post trunc err", oe1, 1'b0);
    chk("long or data", od0, 8'h1F);
    chk("long or count", oc0, 5'd5);
    cyc(0, 2'b00, 8'h00, 0, 1);

    // mode change mid-frame ignored
    cyc(1, 2'b00, 8'h0F, 0, 1);
    cyc(1, 2'b01, 8'hF0, 1, 1);
    chk("mode hold data", od0, 8'h00);
    cyc(0, 2'b00, 8'h00, 0, 1);

    // reset mid-frame
    cyc(1, 2'b00, 8'h11, 0, 1);
    cyc(1, 2'b00, 8'h22, 0, 1);
    rst = 1'b1;
    cyc(1, 2'b00, 8'h33, 1, 1);
    chk("midrst valid", ov0, 1'b0);
    chk("midrst in_ready", rdy0, 1'b0);
    rst = 1'b0;
    cyc(1, 2'b00, 8'h0F, 1, 1);
    chk("after rst data", od0, 8'h0F);
    chk("after rst count", oc0, 5'd1);
    cyc(0, 2'b00, 8'h00, 0, 1);

    // randomized traffic
    for (int t = 0; t < 4000; t++) begin
      rst = ($urandom_range(0, 199) == 0);
      cyc($urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)), 8'($urandom),
          $urandom_range(0, 5) == 0, $urandom_range(0, 9) < 7);
    end
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
